// File: rtl/hdmi_sched_pkg.sv
// Shared definitions for the block stream scheduler.
// Holds the scheduler FSM state type, the default beats-per-block and gap lengths,
// and helpers that derive per-instance constants from the pixels-per-beat parameter.
package hdmi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLOCK,
        H_GAP,
        V_GAP
    } sched_state_t;

    localparam int PIX_PER_BLK   = 64;
    localparam int DEF_N         = 2;
    localparam int BLK_BEATS     = PIX_PER_BLK / DEF_N;
    localparam int DEF_H_GAP_CYC = 848;
    localparam int DEF_V_GAP_CYC = 299112;

    function automatic int blk_beats(input int n);
        return PIX_PER_BLK / n;
    endfunction

    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt) + 1;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter used to time the idle gaps between strips and frames.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         loads load_val into the counter (takes priority over counting)
//   load_val     number of cycles the gap lasts
//   done         high on the last cycle of the gap (counter at terminal count 1)
module gap_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Loaded on the cycle before the gap begins, so a value of L gives L gap cycles
    // with done on the L-th one.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/blk_stream_scheduler.sv
// Block stream scheduler: forwards upstream pixel beats as 8x8 blocks toward
// blocks_to_hdmi, inserting an idle gap after each 8-line strip and after each frame.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   en                                permits a frame to start (sampled at frame start only)
//   src_valid / src_ready             upstream handshake
//   src_data_y/cr/cb                  upstream pixels, N per beat
//   blk_valid/sob/eob/sof             block framing, registered one cycle after acceptance
//   blk_data_y/cr/cb                  registered pixels, held between valid beats
//   frame_done                        one-cycle pulse on the last cycle of the frame gap
//   underrun                          one-cycle pulse per missing beat inside a block
//   underrun_cnt                      saturating underrun count, cleared at frame start
//                                     (present only with SCHED_UNDERRUN_CNT_EN defined)
//
// state  | meaning
// IDLE   | waiting for en to start a frame
// BLOCK  | accepting beats of the current block
// H_GAP  | idle gap after a strip that is not the last
// V_GAP  | idle gap after the last strip of the frame
module blk_stream_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int X_RES     = 2160,
    parameter int Y_RES     = 1200,
    parameter int H_GAP_CYC = DEF_H_GAP_CYC,
    parameter int V_GAP_CYC = DEF_V_GAP_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic signed [N-1:0][7:0] src_data_y,
    input  logic signed [N-1:0][7:0] src_data_cr,
    input  logic signed [N-1:0][7:0] src_data_cb,
    output logic                     blk_valid,
    output logic                     blk_sob,
    output logic                     blk_eob,
    output logic                     blk_sof,
    output logic signed [N-1:0][7:0] blk_data_y,
    output logic signed [N-1:0][7:0] blk_data_cr,
    output logic signed [N-1:0][7:0] blk_data_cb,
    output logic                     frame_done,
    output logic                     underrun
`ifdef SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int BEATS   = blk_beats(N);
    localparam int BLKS    = X_RES / 8;
    localparam int STRIPS  = Y_RES / 8;
    localparam int BW      = cnt_width(BEATS);
    localparam int KW      = cnt_width(BLKS);
    localparam int SW      = cnt_width(STRIPS);
    localparam int GAP_MAX = (H_GAP_CYC > V_GAP_CYC) ? H_GAP_CYC : V_GAP_CYC;
    localparam int GW      = cnt_width(GAP_MAX);

    sched_state_t  state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [KW-1:0] blk_cnt;
    logic [SW-1:0] strip_cnt;
    logic          fire, beat_last, blk_last, strip_last;
    logic          cnt_clr, gap_load, gap_done, underrun_nxt;
    logic [GW-1:0] gap_val;

    assign src_ready    = (state == BLOCK);
    assign fire         = src_ready & src_valid;
    assign beat_last    = (beat_cnt == BW'(BEATS - 1));
    assign blk_last     = (blk_cnt == KW'(BLKS - 1));
    assign strip_last   = (strip_cnt == SW'(STRIPS - 1));
    // Beat 0 has not started the block yet, so a missing beat there is not an underrun.
    assign underrun_nxt = src_ready & ~src_valid & (beat_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        gap_load   = 1'b0;
        gap_val    = '0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = BLOCK;
                    cnt_clr   = 1'b1;
                end
            end
            BLOCK: begin
                if (fire && beat_last && blk_last) begin
                    gap_load = 1'b1;
                    if (strip_last) begin
                        state_nxt = V_GAP;
                        gap_val   = GW'(V_GAP_CYC);
                    end else begin
                        state_nxt = H_GAP;
                        gap_val   = GW'(H_GAP_CYC);
                    end
                end
            end
            H_GAP: begin
                if (gap_done) state_nxt = BLOCK;
            end
            V_GAP: begin
                if (gap_done) begin
                    frame_done = 1'b1;
                    if (en) begin
                        state_nxt = BLOCK;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            blk_cnt   <= '0;
            strip_cnt <= '0;
        end else if (cnt_clr) begin
            beat_cnt  <= '0;
            blk_cnt   <= '0;
            strip_cnt <= '0;
        end else if (fire) begin
            if (beat_last) begin
                beat_cnt <= '0;
                if (blk_last) begin
                    blk_cnt   <= '0;
                    strip_cnt <= strip_last ? '0 : strip_cnt + SW'(1);
                end else begin
                    blk_cnt <= blk_cnt + KW'(1);
                end
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_valid   <= 1'b0;
            blk_sob     <= 1'b0;
            blk_eob     <= 1'b0;
            blk_sof     <= 1'b0;
            underrun    <= 1'b0;
            blk_data_y  <= '0;
            blk_data_cr <= '0;
            blk_data_cb <= '0;
        end else begin
            blk_valid <= fire;
            blk_sob   <= fire & (beat_cnt == '0);
            blk_eob   <= fire & beat_last;
            blk_sof   <= fire & (beat_cnt == '0) & (blk_cnt == '0) & (strip_cnt == '0);
            underrun  <= underrun_nxt;
            if (fire) begin
                blk_data_y  <= src_data_y;
                blk_data_cr <= src_data_cr;
                blk_data_cb <= src_data_cb;
            end
        end
    end

    gap_timer #(.W(GW)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_val),
        .done     (gap_done)
    );

`ifdef SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (cnt_clr) begin
            underrun_cnt <= '0;
        end else if (underrun_nxt && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_blk_stream_scheduler.sv
// Self-checking bench for blk_stream_scheduler with a small 16x16 frame.
module tb_blk_stream_scheduler;

    localparam int N      = 2;
    localparam int HG     = 10;
    localparam int VG     = 20;
    localparam int BEATS  = 32;
    localparam int FBEATS = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic src_valid = 1'b0;
    logic src_ready;
    logic signed [N-1:0][7:0] src_data_y = '0, src_data_cr = '0, src_data_cb = '0;
    logic blk_valid, blk_sob, blk_eob, blk_sof, frame_done, underrun;
    logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;
`ifdef SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    blk_stream_scheduler #(
        .N(N), .X_RES(16), .Y_RES(16), .H_GAP_CYC(HG), .V_GAP_CYC(VG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_data_y(src_data_y), .src_data_cr(src_data_cr), .src_data_cb(src_data_cb),
        .blk_valid(blk_valid), .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
        .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb),
        .frame_done(frame_done), .underrun(underrun)
`ifdef SCHED_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: {y, cr, cb, sob, eob, sof}
    logic [50:0] sb_q[$];
    int gap_q[$];

    // Stimulus controls (written by the main sequence only)
    bit run_src = 1'b0;
    int drop_beat = -1;
    int drop_len = 0;
    int drop_id = 0;

    // Driver state
    int beat_k = 0;
    int seq = 0;
    int drop_seen = 0;
    int drop_left = 0;

    always @(negedge clk) begin
        logic v;
        logic [50:0] e;
        if (drop_id != drop_seen) begin
            drop_seen = drop_id;
            drop_left = drop_len;
        end
        v = run_src;
        if (v && drop_left > 0 && (beat_k % BEATS) == drop_beat) begin
            v = 1'b0;
            drop_left--;
        end
        src_valid = v;
        for (int i = 0; i < N; i++) begin
            src_data_y[i]  = 8'(seq * 2 + i);
            src_data_cr[i] = 8'(seq) ^ 8'h5A ^ 8'(i);
            src_data_cb[i] = 8'(255 - seq - i);
        end
        if (!rst_n) begin
            sb_q.delete();
            beat_k = 0;
        end else if (v && src_ready) begin
            e = {src_data_y, src_data_cr, src_data_cb,
                 (beat_k % BEATS) == 0, (beat_k % BEATS) == BEATS - 1, beat_k == 0};
            sb_q.push_back(e);
            beat_k = (beat_k + 1) % FBEATS;
            seq++;
        end
    end

    // Monitor
    int n_valid = 0, n_sof = 0, n_sob = 0, n_eob = 0, n_underrun = 0, n_done = 0;
    int zrun = 0, blk_run = 0, since_eob = 0;
    bit seen_valid = 1'b0;
    logic [47:0] last_data = '0;

    always @(negedge clk) begin
        logic [50:0] e;
        if (!rst_n) begin
            zrun = 0;
            blk_run = 0;
            seen_valid = 1'b0;
            last_data = '0;
        end else begin
            since_eob++;
            if (blk_valid) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat", {blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof}, e);
                end
                if (seen_valid && zrun > 0) gap_q.push_back(zrun);
                zrun = 0;
                seen_valid = 1'b1;
                blk_run = blk_sob ? 1 : blk_run + 1;
                if (blk_sof) n_sof++;
                if (blk_sob) n_sob++;
                if (blk_eob) begin
                    n_eob++;
                    chk("blk_len", blk_run, BEATS);
                    since_eob = 0;
                end
                last_data = {blk_data_y, blk_data_cr, blk_data_cb};
            end else begin
                zrun++;
                chk("idle_flags", {blk_sob, blk_eob, blk_sof}, 0);
                chk("data_hold", {blk_data_y, blk_data_cr, blk_data_cb}, last_data);
            end
            if (underrun) begin
                n_underrun++;
                chk("underrun_no_valid", blk_valid, 0);
            end
            if (frame_done) begin
                n_done++;
                chk("done_pos", since_eob, VG - 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 2000) begin
            tick();
            t++;
        end
        chk("wait_done_timeout", n_done >= target, 1);
    endtask

    task automatic wait_beat(input int target);
        int t = 0;
        while (beat_k < target && t < 2000) begin
            tick();
            t++;
        end
        chk("wait_beat_timeout", beat_k >= target, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_flags"}, {blk_valid, blk_sob, blk_eob, blk_sof, frame_done, underrun}, 0);
        chk({tag, "_data"}, {blk_data_y, blk_data_cr, blk_data_cb}, 0);
    endtask

    initial begin
        int exp_gaps[4];
        int s_valid, s_sof, s_und, t;
        exp_gaps[0] = 3;
        exp_gaps[1] = HG;
        exp_gaps[2] = VG;
        exp_gaps[3] = HG;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_ready", src_ready, 0);

        // Frame A with a 3-cycle underrun at beat 5; frame B follows back to back.
        run_src   = 1'b1;
        drop_beat = 5;
        drop_len  = 3;
        drop_id++;
        en = 1'b1;
        wait_done(1);
        chk("fa_sof", n_sof, 1);
        chk("fa_sob", n_sob, 4);
        chk("fa_eob", n_eob, 4);
        chk("fa_underrun", n_underrun, 3);

        // Drop en during strip 1 of frame B; the frame must still complete.
        wait_beat(70);
        en = 1'b0;
        wait_done(2);
        chk("fb_sof", n_sof, 2);
        chk("fb_sob", n_sob, 8);
        chk("fb_eob", n_eob, 8);
        chk("gap_count", gap_q.size(), 4);
        for (int i = 0; i < 4 && i < gap_q.size(); i++) chk("gap_len", gap_q[i], exp_gaps[i]);
        s_valid = n_valid;
        repeat (40) tick();
        chk("idle_after_frame", n_valid, s_valid);
        chk("idle_ready", src_ready, 0);

        // Reset at beat 17 of block 1.
        en = 1'b1;
        wait_beat(BEATS + 17);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        drop_beat = 3;
        drop_len  = 5;
        drop_id++;
        repeat (2) tick();
        s_valid = n_valid;
        s_sof   = n_sof;
        s_und   = n_underrun;
        rst_n = 1'b1;
        t = 0;
        while (n_valid == s_valid && t < 50) begin
            tick();
            t++;
        end
        chk("post_rst_first_valid", n_valid > s_valid, 1);
        chk("post_rst_sof", n_sof - s_sof, 1);
        wait_beat(20);
        chk("post_rst_underruns", n_underrun - s_und, 5);
`ifdef SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt_5", underrun_cnt, 5);
`endif
        wait_done(3);
`ifdef SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt_clr", underrun_cnt, 0);
`endif
        chk("post_rst_underruns_end", n_underrun - s_und, 5);
        en = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
